// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit type encoding carried in the flit MSBs and a decode helper.
package noc_pkg;

  localparam int FLIT_TYPE_WIDTH_DEF = 2;

  typedef enum logic [FLIT_TYPE_WIDTH_DEF-1:0] {
    PAYLOAD = 2'b00,
    HEADER  = 2'b01,
    LAST    = 2'b10,
    SINGLE  = 2'b11
  } flit_type_t;

  function automatic flit_type_t flit_type(input logic [FLIT_TYPE_WIDTH_DEF-1:0] type_bits);
    return flit_type_t'(type_bits);
  endfunction

endpackage

// File: rtl/noc_arb_rr.sv
// Combinational round-robin picker: first requester at index >= rr_ptr, wrapping modulo NUM_SRC.
module noc_arb_rr #(
  parameter  int NUM_SRC = 3,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!gnt_any && req[(int'(rr_ptr) + k) % NUM_SRC]) begin
        gnt_any                             = 1'b1;
        gnt[(int'(rr_ptr) + k) % NUM_SRC]   = 1'b1;
        gnt_idx                             = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC output VC between NUM_SRC flit sources,
// with a registered one-entry output stage and sticky protocol/length error flags.
module noc_packet_arbiter
  import noc_pkg::*;
#(
  parameter  int FLIT_DATA_WIDTH = 32,
  parameter  int FLIT_TYPE_WIDTH = FLIT_TYPE_WIDTH_DEF,
  parameter  int NUM_SRC         = 3,
  parameter  int MAX_FLITS       = 32,
  localparam int FLIT_W          = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  localparam int IDX_W           = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*FLIT_W-1:0] in_flit,
  input  logic [NUM_SRC-1:0]        in_valid,
  output logic [NUM_SRC-1:0]        in_ready,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_owner,
  output logic                      err_proto,
  output logic                      err_len
);

  localparam int CNT_W = $clog2(MAX_FLITS + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   len_cnt;

  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] stray;
  logic [NUM_SRC-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               acc;
  logic               xfer;
  logic [IDX_W-1:0]   sel_idx;
  logic [FLIT_W-1:0]  sel_flit;
  flit_type_t         sel_type;

  function automatic logic [IDX_W-1:0] next_src(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_SRC - 1) ? '0 : i + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    flit_type_t t;
    assign t        = flit_type(in_flit[i*FLIT_W + FLIT_W - 1 -: FLIT_TYPE_WIDTH]);
    assign cand[i]  = in_valid[i] && (t == HEADER || t == SINGLE);
    assign stray[i] = in_valid[i] && (t == PAYLOAD || t == LAST);
  end

  noc_arb_rr #(.NUM_SRC(NUM_SRC)) u_arb (
    .req     (cand),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Handshake: a flit moves from source g when in_valid[g] && in_ready[g]; in_ready is asserted
  // only when the output stage is empty or drains this cycle, and out_flit moves downstream on
  // out_valid && out_ready. At most one in_ready bit is ever high.
  assign acc = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (!rst && acc) begin
      if (state == ST_IDLE) in_ready = gnt;
      else                  in_ready[owner] = 1'b1;
    end
  end

  assign xfer     = |(in_ready & in_valid);
  assign sel_idx  = (state == ST_IDLE) ? gnt_idx : owner;
  assign sel_flit = in_flit[int'(sel_idx)*FLIT_W +: FLIT_W];
  assign sel_type = flit_type(sel_flit[FLIT_W-1 -: FLIT_TYPE_WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flit  <= '0;
      out_owner <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_flit  <= sel_flit;
      out_owner <= sel_idx;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      len_cnt   <= '0;
      err_proto <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      // A mid-packet flit with no lock is never granted; it just flags and stalls.
      if (state == ST_IDLE && |stray) err_proto <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (sel_type == HEADER) begin
              state   <= ST_LOCKED;
              owner   <= sel_idx;
              len_cnt <= CNT_W'(1);
            end else begin
              rr_ptr  <= next_src(sel_idx);
            end
          end
        end
        ST_LOCKED: begin
          if (xfer) begin
            if (sel_type == LAST) begin
              state   <= ST_IDLE;
              rr_ptr  <= next_src(owner);
              len_cnt <= '0;
            end else begin
              if (sel_type == HEADER || sel_type == SINGLE) err_proto <= 1'b1;
              if (len_cnt == CNT_W'(MAX_FLITS)) err_len <= 1'b1;
              else                              len_cnt <= len_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Bench for noc_packet_arbiter: directed scenarios plus randomized packet traffic, all checked
// every cycle against a packet-level reference model and an expected-flit queue.
module tb_noc_packet_arbiter;
  import noc_pkg::*;

  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int FW   = 34;
  localparam int IW   = 2;
  localparam int MAXF = 4;

  localparam logic [1:0] T_PAY = 2'b00;
  localparam logic [1:0] T_HDR = 2'b01;
  localparam logic [1:0] T_LST = 2'b10;
  localparam logic [1:0] T_SGL = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*FW-1:0] in_flit;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [FW-1:0]   out_flit;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_owner;
  logic            err_proto;
  logic            err_len;

  noc_packet_arbiter #(
    .FLIT_DATA_WIDTH (DW),
    .FLIT_TYPE_WIDTH (2),
    .NUM_SRC         (N),
    .MAX_FLITS       (MAXF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_owner (out_owner),
    .err_proto (err_proto),
    .err_len   (err_len)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: {owner, flit} in acceptance order
  logic [FW+IW-1:0] exp_q[$];

  // packet-level reference model
  int            m_owner;   // -1 when no packet holds the link
  int            m_rr;
  int            m_len;
  bit            m_errp;
  bit            m_errl;
  bit            m_ov;
  logic [FW-1:0] m_of;
  int            m_oo;
  logic [N-1:0]  m_rdy;

  logic [FW-1:0] src_q[N][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ftype(input logic [FW-1:0] f);
    return f[FW-1 -: 2];
  endfunction

  // driver tasks
  task automatic drive(input int i, input logic [1:0] t, input logic [31:0] d, input logic v);
    in_flit[i*FW +: FW] = {t, d};
    in_valid[i]         = v;
  endtask

  task automatic clr_all();
    in_valid = '0;
    in_flit  = '0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_len   = 0;
    m_errp  = 0;
    m_errl  = 0;
    m_ov    = 0;
    m_of    = '0;
    m_oo    = 0;
    exp_q.delete();
  endtask

  // One cycle: entered at a negedge with inputs already driven, returns at the next negedge.
  task automatic step();
    logic [FW-1:0]    f;
    logic [FW+IW-1:0] item;
    logic [1:0]       t;
    int               g;
    #1;
    if (rst) model_reset();
    m_rdy = '0;
    if (!rst && (!m_ov || out_ready)) begin
      if (m_owner < 0) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          f = in_flit[((m_rr + k) % N)*FW +: FW];
          if (g < 0 && in_valid[(m_rr + k) % N] && (ftype(f) == T_HDR || ftype(f) == T_SGL))
            g = (m_rr + k) % N;
        end
        if (g >= 0) m_rdy[g] = 1'b1;
      end else begin
        m_rdy[m_owner] = 1'b1;
      end
    end

    chk("in_ready",  in_ready,  m_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("out_flit",  out_flit,  m_of);
    chk("out_owner", out_owner, m_oo);
    chk("err_proto", err_proto, m_errp);
    chk("err_len",   err_len,   m_errl);

    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("stream_extra", exp_q.size(), 1);
      else begin
        item = exp_q.pop_front();
        chk("stream_flit",  out_flit,  item[FW-1:0]);
        chk("stream_owner", out_owner, item[FW+IW-1:FW]);
      end
    end

    if (!rst) begin
      if (m_owner < 0)
        for (int i = 0; i < N; i++)
          if (in_valid[i] && (ftype(in_flit[i*FW +: FW]) == T_PAY || ftype(in_flit[i*FW +: FW]) == T_LST))
            m_errp = 1;
      g = -1;
      for (int i = 0; i < N; i++) if (m_rdy[i] && in_valid[i]) g = i;
      if (g >= 0) begin
        f = in_flit[g*FW +: FW];
        t = ftype(f);
        exp_q.push_back({IW'(g), f});
        m_of = f;
        m_oo = g;
        m_ov = 1;
        if (m_owner < 0) begin
          if (t == T_HDR) begin m_owner = g; m_len = 1; end
          else m_rr = (g + 1) % N;
        end else if (t == T_LST) begin
          m_rr = (m_owner + 1) % N;
          m_owner = -1;
          m_len = 0;
        end else begin
          if (t == T_HDR || t == T_SGL) m_errp = 1;
          if (m_len == MAXF) m_errl = 1;
          else m_len++;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic gen_pkt(input int i);
    int len;
    len = $urandom_range(1, 6);
    if (len == 1) src_q[i].push_back({T_SGL, 32'($urandom)});
    else begin
      src_q[i].push_back({T_HDR, 32'($urandom)});
      for (int k = 0; k < len - 2; k++) src_q[i].push_back({T_PAY, 32'($urandom)});
      src_q[i].push_back({T_LST, 32'($urandom)});
    end
  endtask

  initial begin
    int left;
    int cyc;
    rst       = 1'b1;
    out_ready = 1'b1;
    clr_all();
    model_reset();
    @(negedge clk);

    // reset: combinational ready is held low even with a grantable flit present
    drive(0, T_SGL, 32'h1, 1'b1);
    #1 chk("rst_in_ready", in_ready, 3'b000);
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_flit",  out_flit,  34'h0);
    chk("rst_errs",      {err_proto, err_len}, 2'b00);
    clr_all();
    rst = 1'b0;

    // 1: three SINGLEs at once are served 0,1,2 back to back
    drive(0, T_SGL, 32'h10, 1'b1);
    drive(1, T_SGL, 32'h11, 1'b1);
    drive(2, T_SGL, 32'h12, 1'b1);
    #1 chk("t1_ready0", in_ready, 3'b001);
    step();
    chk("t1_owner0", {out_valid, out_owner}, {1'b1, 2'd0});
    drive(0, T_SGL, 32'h10, 1'b0);
    #1 chk("t1_ready1", in_ready, 3'b010);
    step();
    chk("t1_owner1", {out_valid, out_owner}, {1'b1, 2'd1});
    drive(1, T_SGL, 32'h11, 1'b0);
    step();
    chk("t1_owner2", {out_valid, out_owner}, {1'b1, 2'd2});
    drive(2, T_SGL, 32'h12, 1'b0);
    step();
    chk("t1_drained", out_valid, 1'b0);

    // 2: src1 packet holds the link against a waiting src0 SINGLE
    drive(1, T_HDR, 32'h20, 1'b1);
    step();
    chk("t2_hdr_owner", out_owner, 2'd1);
    drive(1, T_PAY, 32'h21, 1'b1);
    drive(0, T_SGL, 32'h2f, 1'b1);
    #1 chk("t2_lock_pay", in_ready, 3'b010);
    step();
    drive(1, T_LST, 32'h22, 1'b1);
    #1 chk("t2_lock_last", in_ready, 3'b010);
    step();
    drive(1, T_LST, 32'h22, 1'b0);
    drive(2, T_SGL, 32'h2e, 1'b1);
    #1 chk("t2_rr_after_last", in_ready, 3'b100);
    step();
    drive(2, T_SGL, 32'h2e, 1'b0);
    #1 chk("t2_src0_served", in_ready, 3'b001);
    step();
    drive(0, T_SGL, 32'h2f, 1'b0);
    step();
    step();

    // 3: backpressure mid-packet holds the stage and blocks all sources
    drive(0, T_HDR, 32'h30, 1'b1);
    step();
    drive(0, T_PAY, 32'h3333_0001, 1'b1);
    step();
    out_ready = 1'b0;
    drive(0, T_PAY, 32'h3333_0002, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_bp_ready", in_ready, 3'b000);
      step();
      chk("t3_bp_hold", {out_valid, out_flit}, {1'b1, T_PAY, 32'h3333_0001});
    end
    out_ready = 1'b1;
    step();
    drive(0, T_LST, 32'h3333_0003, 1'b1);
    step();
    drive(0, T_LST, 32'h3333_0003, 1'b0);
    step();
    step();

    // 4: stray PAYLOAD in idle flags and stalls; other sources keep flowing
    drive(2, T_PAY, 32'h40, 1'b1);
    step();
    chk("t4_err_proto", err_proto, 1'b1);
    drive(1, T_SGL, 32'h41, 1'b1);
    #1 chk("t4_src1", in_ready, 3'b010);
    step();
    drive(1, T_SGL, 32'h41, 1'b0);
    drive(0, T_SGL, 32'h42, 1'b1);
    #1 chk("t4_src0", in_ready, 3'b001);
    step();
    drive(0, T_SGL, 32'h42, 1'b0);
    step();
    step();
    chk("t4_stalled", in_ready, 3'b000);
    do_reset();

    // 5: over-length packet flags on the flit after MAX_FLITS, still forwards all flits
    for (int k = 0; k < 6; k++) begin
      drive(1, (k == 0) ? T_HDR : ((k == 5) ? T_LST : T_PAY), 32'(32'h50 + k), 1'b1);
      step();
      chk("t5_err_len", err_len, (k >= 4) ? 1'b1 : 1'b0);
    end
    drive(1, T_LST, 32'h55, 1'b0);
    drive(0, T_SGL, 32'h5f, 1'b1);
    #1 chk("t5_back_idle", in_ready, 3'b001);
    step();
    drive(0, T_SGL, 32'h5f, 1'b0);
    step();
    step();
    do_reset();

    // 6: reset mid-packet flushes at once; rr restarts at 0
    drive(1, T_HDR, 32'h60, 1'b1);
    step();
    drive(1, T_PAY, 32'h61, 1'b1);
    rst = 1'b1;
    #1 chk("t6_flush", {out_valid, in_ready}, 4'b0000);
    step();
    rst = 1'b0;
    drive(0, T_HDR, 32'h62, 1'b1);
    drive(1, T_HDR, 32'h63, 1'b1);
    #1 chk("t6_rr0", in_ready, 3'b001);
    step();
    chk("t6_owner0", {out_valid, out_owner}, {1'b1, 2'd0});
    drive(0, T_LST, 32'h64, 1'b1);
    step();
    drive(0, T_LST, 32'h64, 1'b0);
    #1 chk("t6_next_src1", in_ready, 3'b010);
    step();
    drive(1, T_LST, 32'h65, 1'b1);
    step();
    clr_all();
    step();
    do_reset();

    // randomized legal traffic with gaps and backpressure
    for (int i = 0; i < N; i++) for (int p = 0; p < 30; p++) gen_pkt(i);
    cyc = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size()) > 0 && cyc < 20000) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          in_flit[i*FW +: FW] = src_q[i][0];
          in_valid[i] = ($urandom_range(0, 3) != 0);
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      for (int i = 0; i < N; i++) if (m_rdy[i] && in_valid[i]) void'(src_q[i].pop_front());
      cyc++;
    end
    clr_all();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    left = src_q[0].size() + src_q[1].size() + src_q[2].size();
    chk("rand_leftover", left, 0);
    chk("rand_exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
